// File: rtl/axi_lite_rd_arbiter_if.sv
// AXI4-Lite read-channel bundle (AR + R) used for both requester ports and the downstream port.
// The master modport drives AR and accepts R; the slave modport is its mirror.
interface axi_lite_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (output araddr, arprot, arvalid, rready,
                    input  arready, rdata, rresp, rvalid);
    modport slave  (input  araddr, arprot, arvalid, rready,
                    output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/axi_lite_rd_arbiter.sv
// Round-robin two-requester AXI4-Lite read arbiter, one outstanding read at a time.
// Define RD_TIMEOUT_EN to add the watchdog that answers a stalled read with SLVERR.
module axi_lite_rd_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi_lite_rd_arbiter_if.slave  s0,
    axi_lite_rd_arbiter_if.slave  s1,
    axi_lite_rd_arbiter_if.master m,
    output logic                  arb_busy,
    output logic                  arb_grant
);

`ifdef RD_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'b00, ADDR = 2'b01, DATA = 2'b10, ERR = 2'b11} state_t;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_r;
    logic             timeout_s;
`else
    typedef enum logic [1:0] {IDLE = 2'b00, ADDR = 2'b01, DATA = 2'b10} state_t;
`endif

    state_t            state_r;
    state_t            next_state_s;
    logic              accept_s;
    logic              win_s;
    logic              sel_rready_s;
    logic              r_hs_s;
    logic              rr_ptr_r;
    logic              grant_r;
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        prot_r;

    // Winner selection: a lone requester wins outright, a tie goes to rr_ptr.
    always_comb begin
        accept_s     = 1'b0;
        win_s        = 1'b0;
        sel_rready_s = grant_r ? s1.rready : s0.rready;
        r_hs_s       = (state_r == DATA) && m.rvalid && sel_rready_s;
        if ((state_r == IDLE) && rst_n) begin
            accept_s = s0.arvalid | s1.arvalid;
            win_s    = (s0.arvalid & s1.arvalid) ? rr_ptr_r : s1.arvalid;
        end else begin
            accept_s = 1'b0;
            win_s    = 1'b0;
        end
    end

`ifdef RD_TIMEOUT_EN
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: restarts on every accept and runs while a read is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ADDR) || (state_r == DATA)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Accept-cycle capture: requester address/prot, owner, and pointer moved past the winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r <= 1'b0;
            grant_r  <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            prot_r   <= 3'b000;
        end else if (accept_s) begin
            rr_ptr_r <= ~win_s;
            grant_r  <= win_s;
            addr_r   <= win_s ? s1.araddr : s0.araddr;
            prot_r   <= win_s ? s1.arprot : s0.arprot;
        end else begin
            rr_ptr_r <= rr_ptr_r;
            grant_r  <= grant_r;
            addr_r   <= addr_r;
            prot_r   <= prot_r;
        end
    end

    // Next-state logic; an R handshake in the same cycle as the timeout wins.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_state_s = ADDR;
                else          next_state_s = IDLE;
            end
            ADDR: begin
`ifdef RD_TIMEOUT_EN
                if (timeout_s)      next_state_s = ERR;
                else if (m.arready) next_state_s = DATA;
                else                next_state_s = ADDR;
`else
                if (m.arready) next_state_s = DATA;
                else           next_state_s = ADDR;
`endif
            end
            DATA: begin
`ifdef RD_TIMEOUT_EN
                if (r_hs_s)         next_state_s = IDLE;
                else if (timeout_s) next_state_s = ERR;
                else                next_state_s = DATA;
`else
                if (r_hs_s) next_state_s = IDLE;
                else        next_state_s = DATA;
`endif
            end
`ifdef RD_TIMEOUT_EN
            ERR: begin
                if (sel_rready_s) next_state_s = IDLE;
                else              next_state_s = ERR;
            end
`endif
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode: only the owner ever sees R traffic; the other port is held at zero.
    always_comb begin
        s0.arready = 1'b0;
        s1.arready = 1'b0;
        s0.rvalid  = 1'b0;
        s1.rvalid  = 1'b0;
        s0.rdata   = {DATA_W{1'b0}};
        s1.rdata   = {DATA_W{1'b0}};
        s0.rresp   = 2'b00;
        s1.rresp   = 2'b00;
        m.araddr   = addr_r;
        m.arprot   = prot_r;
        m.arvalid  = 1'b0;
        m.rready   = 1'b0;
        arb_busy   = (state_r != IDLE);
        arb_grant  = grant_r;
        case (state_r)
            IDLE: begin
                s0.arready = accept_s & ~win_s;
                s1.arready = accept_s & win_s;
            end
            ADDR: m.arvalid = 1'b1;
            DATA: begin
                m.rready = sel_rready_s;
                if (grant_r) begin
                    s1.rvalid = m.rvalid;
                    s1.rdata  = m.rdata;
                    s1.rresp  = m.rresp;
                end else begin
                    s0.rvalid = m.rvalid;
                    s0.rdata  = m.rdata;
                    s0.rresp  = m.rresp;
                end
            end
`ifdef RD_TIMEOUT_EN
            ERR: begin
                if (grant_r) begin
                    s1.rvalid = 1'b1;
                    s1.rresp  = 2'b10;
                end else begin
                    s0.rvalid = 1'b1;
                    s0.rresp  = 2'b10;
                end
            end
`endif
            default: m.arvalid = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Scoreboard bench for axi_lite_rd_arbiter: stimulus pushes expected AR/R transfers,
// independent monitors pop and compare whenever the DUT presents them.
module tb_axi_lite_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic arb_busy, arb_grant;
    always #5 clk = ~clk;

    axi_lite_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s0 ();
    axi_lite_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s1 ();
    axi_lite_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m ();

    axi_lite_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .s0(s0), .s1(s1), .m(m),
        .arb_busy(arb_busy), .arb_grant(arb_grant));

    typedef struct {logic port; logic [31:0] addr; logic [2:0] prot;} ar_exp_t;
    typedef struct {logic port; logic [31:0] data; logic [1:0] resp;} r_exp_t;
    typedef struct {logic [31:0] addr; logic [2:0] prot;} req_t;

    ar_exp_t exp_ar_q[$];
    r_exp_t  exp_r_q[$];
    req_t    req_q0[$];
    req_t    req_q1[$];
    int      checks = 0;
    int      failures = 0;

    int       ar_stall_cfg = 0;
    int       r_lat_cfg = 1;
    logic [1:0] resp_cfg = 2'b00;
    bit       r_never = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic port, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input bit expect_r);
        req_t rq; ar_exp_t ea; r_exp_t er;
        rq.addr = addr;
        rq.prot = port ? 3'b001 : 3'b100;
        if (port) req_q1.push_back(rq); else req_q0.push_back(rq);
        ea.port = port; ea.addr = addr; ea.prot = rq.prot;
        exp_ar_q.push_back(ea);
        if (expect_r) begin
            er.port = port; er.data = data; er.resp = resp;
            exp_r_q.push_back(er);
        end
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while ((exp_ar_q.size() != 0 || exp_r_q.size() != 0 || arb_busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_in_budget"}, 64'(n < budget), 64'd1);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_busy"}, arb_busy, 0);
        chk({nm, "_grant"}, arb_grant, 0);
        chk({nm, "_m_arvalid"}, m.arvalid, 0);
        chk({nm, "_m_araddr"}, m.araddr, 0);
        chk({nm, "_m_arprot"}, m.arprot, 0);
        chk({nm, "_m_rready"}, m.rready, 0);
        chk({nm, "_s0_arready"}, s0.arready, 0);
        chk({nm, "_s1_arready"}, s1.arready, 0);
        chk({nm, "_s0_rvalid"}, s0.rvalid, 0);
        chk({nm, "_s1_rvalid"}, s1.rvalid, 0);
        chk({nm, "_s0_rdata_rresp"}, {s0.rdata, s0.rresp}, 0);
        chk({nm, "_s1_rdata_rresp"}, {s1.rdata, s1.rresp}, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic r_check(input logic port, input logic [31:0] data, input logic [1:0] resp);
        r_exp_t e;
        if (exp_r_q.size() == 0) begin
            chk("r_unexpected_rvalid_port", port, ~port);
        end else begin
            e = exp_r_q.pop_front();
            chk("r_port", port, e.port);
            chk("r_data", data, e.data);
            chk("r_resp", resp, e.resp);
        end
    endtask

    // Requester S0 driver: keeps ARVALID up until accepted, scrambles ARADDR when idle.
    initial begin : drv0
        bit hs;
        s0.arvalid = 1'b0; s0.araddr = 32'hFFFF_FFFF; s0.arprot = 3'b111; s0.rready = 1'b1;
        forever begin
            @(negedge clk); hs = (s0.arvalid === 1'b1) && (s0.arready === 1'b1);
            @(posedge clk); #1;
            if (hs && req_q0.size() > 0) void'(req_q0.pop_front());
            if (req_q0.size() > 0) begin
                s0.arvalid = 1'b1; s0.araddr = req_q0[0].addr; s0.arprot = req_q0[0].prot;
            end else begin
                s0.arvalid = 1'b0; s0.araddr = 32'hFFFF_FFFF; s0.arprot = 3'b111;
            end
        end
    end

    // Requester S1 driver.
    initial begin : drv1
        bit hs;
        s1.arvalid = 1'b0; s1.araddr = 32'hFFFF_FFFF; s1.arprot = 3'b111; s1.rready = 1'b1;
        forever begin
            @(negedge clk); hs = (s1.arvalid === 1'b1) && (s1.arready === 1'b1);
            @(posedge clk); #1;
            if (hs && req_q1.size() > 0) void'(req_q1.pop_front());
            if (req_q1.size() > 0) begin
                s1.arvalid = 1'b1; s1.araddr = req_q1[0].addr; s1.arprot = req_q1[0].prot;
            end else begin
                s1.arvalid = 1'b0; s1.araddr = 32'hFFFF_FFFF; s1.arprot = 3'b111;
            end
        end
    end

    // Downstream slave: data = 0xDEAD0000 | (addr >> 2), configurable stall/latency/response.
    initial begin : slave
        bit pend, ar_hs, r_hs, rst_low;
        logic [31:0] pa, cap;
        int arc, rc;
        m.arready = 1'b0; m.rvalid = 1'b0; m.rdata = 32'h0; m.rresp = 2'b00;
        pend = 1'b0; arc = 0; rc = 0; pa = 32'h0;
        forever begin
            @(negedge clk);
            ar_hs = (m.arvalid === 1'b1) && m.arready;
            r_hs = m.rvalid && (m.rready === 1'b1);
            cap = m.araddr;
            rst_low = !rst_n;
            @(posedge clk); #1;
            if (rst_low) begin
                pend = 1'b0; arc = 0; rc = 0;
                m.arready = 1'b0; m.rvalid = 1'b0; m.rdata = 32'h0; m.rresp = 2'b00;
            end else begin
                if (r_hs) begin pend = 1'b0; m.rvalid = 1'b0; m.rdata = 32'h0; m.rresp = 2'b00; end
                if (ar_hs) begin pend = 1'b1; pa = cap; arc = 0; rc = 0; end
                if ((m.arvalid === 1'b1) && !pend) begin
                    m.arready = (arc >= ar_stall_cfg);
                    arc++;
                end else begin
                    m.arready = 1'b0;
                end
                if (pend && !m.rvalid && !r_never) begin
                    if (rc >= r_lat_cfg) begin
                        m.rvalid = 1'b1; m.rdata = 32'hDEAD_0000 | (pa >> 2); m.rresp = resp_cfg;
                    end else begin
                        rc++;
                    end
                end
            end
        end
    end

    // AR monitor: every cycle M_AXI_ARVALID is up it must carry the expected winner's request.
    initial begin : ar_mon
        forever begin
            @(negedge clk);
            if (rst_n && m.arvalid === 1'b1) begin
                if (exp_ar_q.size() == 0) begin
                    chk("ar_unexpected_arvalid", m.arvalid, 0);
                end else begin
                    chk("ar_addr", m.araddr, exp_ar_q[0].addr);
                    chk("ar_prot", m.arprot, exp_ar_q[0].prot);
                    chk("ar_grant", arb_grant, exp_ar_q[0].port);
                    if (m.arready === 1'b1) void'(exp_ar_q.pop_front());
                end
            end
        end
    end

    // R monitor: compares every requester-side R handshake against the scoreboard.
    initial begin : r_mon
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (s0.rvalid === 1'b1 && s0.rready) r_check(1'b0, s0.rdata, s0.rresp);
                if (s1.rvalid === 1'b1 && s1.rready) r_check(1'b1, s1.rdata, s1.rresp);
            end
        end
    end

    initial begin : main
        int n;
        int lat;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst_init");
        rst_n = 1'b1;

        // Single S0 read.
        @(negedge clk);
        issue(1'b0, 32'h0000_0100, 32'hDEAD_0040, 2'b00, 1'b1);
        wait_done("single_s0", 40);
        chk("single_s0_grant", arb_grant, 0);

        // Simultaneous requests right after reset: S0 first.
        pulse_reset();
        @(negedge clk);
        issue(1'b0, 32'h10, 32'hDEAD_0004, 2'b00, 1'b1);
        issue(1'b1, 32'h20, 32'hDEAD_0008, 2'b00, 1'b1);
        wait_done("tie_after_reset", 60);

        // Continuous requests from both: strict alternation.
        @(negedge clk);
        issue(1'b0, 32'h200, 32'hDEAD_0080, 2'b00, 1'b1);
        issue(1'b1, 32'h300, 32'hDEAD_00C0, 2'b00, 1'b1);
        issue(1'b0, 32'h204, 32'hDEAD_0081, 2'b00, 1'b1);
        issue(1'b1, 32'h304, 32'hDEAD_00C1, 2'b00, 1'b1);
        issue(1'b0, 32'h208, 32'hDEAD_0082, 2'b00, 1'b1);
        issue(1'b1, 32'h308, 32'hDEAD_00C2, 2'b00, 1'b1);
        wait_done("fairness", 200);

        // Downstream AR stall of 5 cycles, then SLVERR.
        ar_stall_cfg = 5; resp_cfg = 2'b10;
        @(negedge clk);
        issue(1'b0, 32'h40, 32'hDEAD_0010, 2'b10, 1'b1);
        wait_done("stall_slverr", 60);
        ar_stall_cfg = 0; resp_cfg = 2'b00;

        // Reset while S1 owns a transaction in DATA: nothing is delivered.
        r_never = 1'b1;
        @(negedge clk);
        issue(1'b1, 32'h80, 32'h0, 2'b00, 1'b0);
        n = 0;
        while (exp_ar_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
        chk("mid_rst_ar_in_budget", 64'(n < 40), 64'd1);
        @(negedge clk);
        chk("mid_rst_in_data_busy", arb_busy, 1);
        chk("mid_rst_in_data_rready", m.rready, 1);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset("rst_mid");
        rst_n = 1'b1;
        r_never = 1'b0;
        @(negedge clk);
        issue(1'b1, 32'h4, 32'hDEAD_0001, 2'b00, 1'b1);
        wait_done("after_mid_rst", 40);
        chk("after_mid_rst_grant", arb_grant, 1);

`ifdef RD_TIMEOUT_EN
        // Slave never answers: watchdog returns SLVERR with zero data.
        r_never = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'h500, 32'h0, 2'b10, 1'b1);
        n = 0;
        while (m.arvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        lat = 0;
        while (s0.rvalid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        chk("timeout_latency_le17", 64'(lat <= 17), 64'd1);
        wait_done("timeout", 60);
        chk("timeout_idle", arb_busy, 0);
        pulse_reset();
        r_never = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
